// File: rtl/mem_bus_controller.sv
// Bus-master front end for a 64k x 16 synchronous memory: single-word read/write
// requests over valid/ready, sequenced onto enable/write_enable/address/data pins.
module mem_bus_controller #(
    parameter int word_size = 16,
    parameter int addr_size = 16,
    parameter int read_wait = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [addr_size-1:0] req_addr,
    input  logic [word_size-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [word_size-1:0] resp_rdata,
    output logic                 mem_enable,
    output logic                 mem_write_enable,
    output logic [addr_size-1:0] mem_address,
    inout  wire  [word_size-1:0] mem_data
);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, RD_DATA} state_t;

    typedef struct packed {
        logic [addr_size-1:0] addr;
        logic [word_size-1:0] wdata;
    } req_t;

    localparam logic [3:0] WAIT_LAST = 4'((read_wait == 0) ? 0 : read_wait - 1);

    state_t     state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    req_t       req_q;
    logic       drive;
    logic       transfer;

    assign transfer    = req_valid && req_ready;
    assign mem_address = req_q.addr;
    // Drive enable is a flop, so the bus is only ever driven during the WRITE cycle.
    assign mem_data    = drive ? req_q.wdata : {word_size{1'bz}};

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (transfer) state_next = req_write ? WRITE : RD_ADDR;
            end
            WRITE: state_next = IDLE;
            RD_ADDR: begin
                wait_cnt_next = '0;
                state_next    = (read_wait > 0) ? RD_WAIT : RD_DATA;
            end
            RD_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next    = RD_DATA;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            RD_DATA: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            req_q            <= '0;
            drive            <= 1'b0;
            req_ready        <= 1'b0;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            mem_enable       <= 1'b0;
            mem_write_enable <= 1'b0;
        end else begin
            state            <= state_next;
            wait_cnt         <= wait_cnt_next;
            drive            <= (state_next == WRITE);
            req_ready        <= (state_next == IDLE);
            // Every completed access returns to IDLE with a one-cycle strobe.
            resp_valid       <= (state == WRITE) || (state == RD_DATA);
            mem_enable       <= (state_next != IDLE);
            mem_write_enable <= (state_next == WRITE);
            if (transfer) begin
                req_q.addr  <= req_addr;
                req_q.wdata <= req_wdata;
            end
            if (state == RD_DATA) resp_rdata <= mem_data;
        end
    end

endmodule

// File: tb/tb_mem_bus_controller.sv
// Scoreboard bench: two controllers (read_wait 0 and 3), each on its own memory model.
module tb_mem_bus_controller;
    localparam int W = 16;
    localparam int A = 16;

    typedef struct {
        logic         wr;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         req_valid [2];
    logic         req_write [2];
    logic [A-1:0] req_addr  [2];
    logic [W-1:0] req_wdata [2];
    logic         req_ready [2];
    logic         resp_valid[2];
    logic [W-1:0] resp_rdata[2];
    logic         mem_enable[2];
    logic         mem_write_enable[2];
    logic [A-1:0] mem_address[2];
    wire  [W-1:0] mem_data0, mem_data1;

    mem_bus_controller #(.word_size(W), .addr_size(A), .read_wait(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .mem_enable(mem_enable[0]), .mem_write_enable(mem_write_enable[0]),
        .mem_address(mem_address[0]), .mem_data(mem_data0)
    );

    mem_bus_controller #(.word_size(W), .addr_size(A), .read_wait(3)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .mem_enable(mem_enable[1]), .mem_write_enable(mem_write_enable[1]),
        .mem_address(mem_address[1]), .mem_data(mem_data1)
    );

    // Synchronous memory models with a backdoor preload port
    logic [W-1:0] mem0 [0:65535];
    logic [W-1:0] mem1 [0:65535];
    logic [W-1:0] q0, q1;
    logic         pl_en[2];
    logic [A-1:0] pl_addr;
    logic [W-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en[0]) mem0[pl_addr] <= pl_data;
        else if (mem_enable[0]) begin
            if (mem_write_enable[0]) mem0[mem_address[0]] <= mem_data0;
            else q0 <= mem0[mem_address[0]];
        end
    end
    always @(posedge clk) begin
        if (pl_en[1]) mem1[pl_addr] <= pl_data;
        else if (mem_enable[1]) begin
            if (mem_write_enable[1]) mem1[mem_address[1]] <= mem_data1;
            else q1 <= mem1[mem_address[1]];
        end
    end
    assign mem_data0 = (mem_enable[0] && !mem_write_enable[0]) ? q0 : {W{1'bz}};
    assign mem_data1 = (mem_enable[1] && !mem_write_enable[1]) ? q1 : {W{1'bz}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    logic [A-1:0] cur_addr [2];
    logic [W-1:0] cur_wdata[2];
    logic         prev_en  [2];
    int           acc_cnt  [2];
    int           run      [2];
    int           last_run [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_resp(input int d);
        exp_t e;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp dut%0d: resp_valid=1, expected none (cycle %0d)", d, cyc);
        end else begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("latency dut%0d", d), cyc, e.due);
            if (!e.wr) chk($sformatf("rdata dut%0d", d), resp_rdata[d], e.data);
        end
    endtask

    // Monitor: address/drive checks every cycle, responses popped from the scoreboard
    initial begin
        for (int d = 0; d < 2; d++) begin
            prev_en[d] = 1'b0; acc_cnt[d] = 0; run[d] = 0; last_run[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mem_enable[d] && !prev_en[d]) acc_cnt[d]++;
                prev_en[d] = mem_enable[d];
                if (mem_enable[d]) run[d]++;
                else begin
                    if (run[d] != 0) last_run[d] = run[d];
                    run[d] = 0;
                end
                if (mem_enable[d]) chk($sformatf("mem_address dut%0d", d), mem_address[d], cur_addr[d]);
                if (mem_write_enable[d])
                    chk($sformatf("mem_data drive dut%0d", d), (d == 0) ? mem_data0 : mem_data1, cur_wdata[d]);
                if (resp_valid[d]) check_resp(d);
            end
        end
    end

    task automatic issue(input int d, input logic wr, input logic [A-1:0] addr,
                         input logic [W-1:0] wdata, input logic [W-1:0] expd,
                         input bit push, output int acc);
        int   waited;
        exp_t e;
        @(negedge clk);
        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata;
        waited = 0;
        while (!req_ready[d] && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[d]) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout dut%0d: req_ready=0, expected 1 within 64 cycles", d);
            acc = -1;
        end else begin
            acc          = cyc;
            cur_addr[d]  = addr;
            cur_wdata[d] = wdata;
            if (push) begin
                e.wr   = wr;
                e.data = expd;
                e.due  = cyc + (wr ? 2 : 3 + ((d == 1) ? 3 : 0));
                if (d == 0) sb0.push_back(e);
                else sb1.push_back(e);
            end
        end
    endtask

    task automatic drop(input int d);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d/%0d responses outstanding, expected 0", sb0.size(), sb1.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic preload(input int d, input logic [A-1:0] addr, input logic [W-1:0] data);
        @(negedge clk);
        pl_en[d] = 1'b1; pl_addr = addr; pl_data = data;
        @(negedge clk);
        pl_en[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int a1, a2, acc0;

    initial begin
        reset = 1'b1;
        pl_en[0] = 1'b0; pl_en[1] = 1'b0; pl_addr = '0; pl_data = '0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
            cur_addr[d] = '0; cur_wdata[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset req_ready dut%0d", d), req_ready[d], 0);
            chk($sformatf("reset resp_valid dut%0d", d), resp_valid[d], 0);
            chk($sformatf("reset resp_rdata dut%0d", d), resp_rdata[d], 0);
            chk($sformatf("reset mem_enable dut%0d", d), mem_enable[d], 0);
            chk($sformatf("reset mem_write_enable dut%0d", d), mem_write_enable[d], 0);
            chk($sformatf("reset mem_address dut%0d", d), mem_address[d], 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("req_ready after reset", req_ready[0], 1);

        preload(0, 16'h0000, 16'h1234);
        preload(0, 16'h0001, 16'h5678);
        preload(0, 16'h0002, 16'h1111);
        preload(1, 16'hFFFF, 16'h0F0F);

        // Write then read back
        issue(0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b1, a1);
        issue(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, a2);
        chk("read accepted on write resp cycle", a2, a1 + 2);
        drop(0);
        drain();

        // Back-to-back reads with req_valid held
        issue(0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b1, a1);
        issue(0, 1'b0, 16'h0001, 16'h0000, 16'h5678, 1'b1, a2);
        chk("b2b read accept spacing", a2, a1 + 3);
        drop(0);
        drain();

        // Read then write to the same address
        issue(0, 1'b0, 16'h0002, 16'h0000, 16'h1111, 1'b1, a1);
        issue(0, 1'b1, 16'h0002, 16'hA5A5, 16'h0000, 1'b1, a2);
        chk("write accepted on read resp cycle", a2, a1 + 3);
        drop(0);
        drain();
        chk("mem[0x0002] after turnaround", mem0[2], 16'hA5A5);
        issue(0, 1'b0, 16'h0002, 16'h0000, 16'hA5A5, 1'b1, a1);
        drop(0);
        drain();

        // Request held during a read in flight is taken exactly once
        acc0 = acc_cnt[0];
        issue(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, a1);
        issue(0, 1'b1, 16'h0020, 16'h3C3C, 16'h0000, 1'b1, a2);
        chk("held write accept cycle", a2, a1 + 3);
        drop(0);
        drain();
        chk("memory accesses for 2 requests", acc_cnt[0] - acc0, 2);
        chk("mem[0x0020] written once", mem0[16'h0020], 16'h3C3C);

        // read_wait=3 on the top address
        issue(1, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 1'b1, a1);
        drop(1);
        drain();
        chk("mem_enable run length rw3", last_run[1], 5);

        // Reset during RD_ADDR aborts the read
        issue(0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b0, a1);
        @(negedge clk);
        chk("in RD_ADDR before reset", mem_enable[0], 1);
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort mem_enable", mem_enable[0], 0);
        chk("abort mem_write_enable", mem_write_enable[0], 0);
        chk("abort resp_valid", resp_valid[0], 0);
        chk("abort resp_rdata", resp_rdata[0], 0);
        reset = 1'b0;
        @(negedge clk);
        chk("req_ready after abort reset", req_ready[0], 1);
        repeat (4) @(negedge clk);
        chk("abort resp_rdata stays 0", resp_rdata[0], 0);
        issue(0, 1'b0, 16'h0001, 16'h0000, 16'h5678, 1'b1, a1);
        drop(0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
